// File: rtl/console_text_sequencer_pkg.sv
// Shared constants, state encoding and address helper for the text console write controller.
package console_pkg;

  localparam int COLS  = 10;
  localparam int ROWS  = 3;
  localparam int CW    = 7;
  localparam int AW    = 5;
  localparam int CELLS = COLS * ROWS;

  localparam logic [AW-1:0] LAST_IDX       = AW'(CELLS - 1);
  localparam logic [AW-1:0] SCROLL_SRC_END = AW'(COLS * (ROWS - 1));
  localparam logic [AW-1:0] ROW_STRIDE     = AW'(COLS);
  localparam logic [3:0]    COL_LAST       = 4'(COLS - 1);
  localparam logic [1:0]    ROW_LAST       = 2'(ROWS - 1);

  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {IDLE, SCROLL, CLEAR} state_t;

  function automatic logic [AW-1:0] cell_addr(input logic [1:0] row, input logic [3:0] col);
    return AW'(row) * ROW_STRIDE + AW'(col);
  endfunction

endpackage

// File: rtl/console_text_sequencer_if.sv
// Byte-stream input channel. valid/ready: a byte transfers on a clock edge where
// in_valid and in_ready are both high; the sender holds in_data stable until then.
interface console_text_sequencer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/console_text_sequencer.sv
// Terminal-style write controller: decodes a byte stream, tracks the cursor and is the
// only writer of the 3x10 character buffer; clear/scroll steps advance only in vblank.
module console_text_sequencer
  import console_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  console_text_sequencer_if.slave  in_if,
  input  logic                     vblank,
  output logic [AW-1:0]            mem_rd_addr,
  input  logic [CW-1:0]            mem_rd_data,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_waddr,
  output logic [CW-1:0]            mem_wdata,
  output logic [3:0]               cursor_col,
  output logic [1:0]               cursor_row,
  output logic                     busy,
  output state_t                   state_dbg
);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [3:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [CW-1:0] wdata_q, wdata_d;
  logic          printable;

  assign printable = (in_if.in_data >= CH_PRINT_LO) && (in_if.in_data <= CH_PRINT_HI);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    col_d       = col_q;
    row_d       = row_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    mem_rd_addr = '0;

    case (state_q)
      IDLE: begin
        if (in_if.in_valid && !in_if.in_data[7]) begin
          if (printable) begin
            we_d    = 1'b1;
            waddr_d = cell_addr(row_q, col_q);
            wdata_d = in_if.in_data[CW-1:0];
            if (col_q == COL_LAST) begin
              col_d = '0;
              if (row_q == ROW_LAST) begin
                state_d = SCROLL;
                idx_d   = '0;
              end else begin
                row_d = row_q + 2'd1;
              end
            end else begin
              col_d = col_q + 4'd1;
            end
          end else if (in_if.in_data == CH_LF) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = SCROLL;
              idx_d   = '0;
            end else begin
              row_d = row_q + 2'd1;
            end
          end else if (in_if.in_data == CH_CR) begin
            col_d = '0;
          end else if (in_if.in_data == CH_BS) begin
            if (col_q != 4'd0) begin
              col_d   = col_q - 4'd1;
              we_d    = 1'b1;
              waddr_d = cell_addr(row_q, col_q - 4'd1);
              wdata_d = CH_SPACE[CW-1:0];
            end
          end else if (in_if.in_data == CH_FF) begin
            col_d   = '0;
            row_d   = '0;
            state_d = CLEAR;
            idx_d   = '0;
          end
        end
      end

      SCROLL, CLEAR: begin
        // Scroll copies the row below into each of the first ROWS-1 rows, then blanks the last.
        if (state_q == SCROLL) mem_rd_addr = idx_q + ROW_STRIDE;
        if (vblank) begin
          we_d    = 1'b1;
          waddr_d = idx_q;
          wdata_d = (state_q == SCROLL && idx_q < SCROLL_SRC_END) ? mem_rd_data
                                                                  : CH_SPACE[CW-1:0];
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      row_q   <= row_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_if.in_ready = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign state_dbg      = state_q;
  assign mem_we         = we_q;
  assign mem_waddr      = waddr_q;
  assign mem_wdata      = wdata_q;
  assign cursor_col     = col_q;
  assign cursor_row     = row_q;

endmodule

// File: tb/tb_console_text_sequencer.sv
// Directed bench for console_text_sequencer: buffer model, write scoreboard, cursor and timing checks.
module tb_console_text_sequencer;
  import console_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          vblank;
  logic [AW-1:0] mem_rd_addr;
  logic [CW-1:0] mem_rd_data;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [CW-1:0] mem_wdata;
  logic [3:0]    cursor_col;
  logic [1:0]    cursor_row;
  logic          busy;
  state_t        state_dbg;

  console_text_sequencer_if in_if();

  console_text_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .in_if       (in_if),
    .vblank      (vblank),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .cursor_col  (cursor_col),
    .cursor_row  (cursor_row),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // character buffer model with a preload port
  logic [CW-1:0] mem [0:31];
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [CW-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_waddr] <= mem_wdata;
  end
  assign mem_rd_data = mem[mem_rd_addr];

  // checking
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // scoreboard
  logic [AW+CW-1:0] exp_q[$];
  logic [CW-1:0]    shadow [0:31];
  logic [AW+CW-1:0] exp_e;

  task automatic push_wr(input logic [AW-1:0] a, input logic [CW-1:0] d);
    exp_q.push_back({a, d});
    shadow[a] = d;
  endtask

  always @(negedge clk) begin
    if (!reset && mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(mem_we), 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check("write", 32'({mem_waddr, mem_wdata}), 32'(exp_e));
      end
    end
  end

  // driver tasks (called at posedge+1)
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_if.in_valid = 1'b1;
    in_if.in_data  = b;
    while (!in_if.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_if.in_ready) check("send_timeout", 32'(in_if.in_ready), 32'd1);
    @(posedge clk); #1;
    in_if.in_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_if.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_if.in_ready) check("ready_timeout", 32'(in_if.in_ready), 32'd1);
  endtask

  task automatic check_cursor(input string tag, input logic [1:0] r, input logic [3:0] c);
    check({tag, "_row"}, 32'(cursor_row), 32'(r));
    check({tag, "_col"}, 32'(cursor_col), 32'(c));
  endtask

  int cyc;

  initial begin
    reset          = 1'b1;
    vblank         = 1'b1;
    in_if.in_valid = 1'b0;
    in_if.in_data  = 8'h00;
    pre_en         = 1'b0;
    pre_addr       = '0;
    pre_data       = '0;

    // reset values and automatic clear
    for (int i = 0; i < CELLS; i++) push_wr(AW'(i), 7'h20);
    repeat (2) @(negedge clk);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_waddr", 32'(mem_waddr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(CLEAR));
    check("rst_ready", 32'(in_if.in_ready), 32'd0);
    check_cursor("rst", 2'd0, 4'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_ready(cyc);
    check("clear_cycles", 32'(cyc), 32'd30);
    @(negedge clk); #1;
    check("clear_drained", 32'(exp_q.size()), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_state", 32'(state_dbg), 32'(IDLE));
    check_cursor("idle", 2'd0, 4'd0);
    @(posedge clk); #1;

    // back-to-back printable writes
    push_wr(5'd0, 7'h41);
    push_wr(5'd1, 7'h42);
    send(8'h41);
    check("a_we", 32'(mem_we), 32'd1);
    check("a_waddr", 32'(mem_waddr), 32'd0);
    check("a_col", 32'(cursor_col), 32'd1);
    send(8'h42);
    check("b_we", 32'(mem_we), 32'd1);
    check("b_waddr", 32'(mem_waddr), 32'd1);
    check("b_col", 32'(cursor_col), 32'd2);

    // CR, row wrap, backspace, ignored bytes
    send(CH_CR);
    check("cr_we", 32'(mem_we), 32'd0);
    check_cursor("cr", 2'd0, 4'd0);
    for (int i = 0; i < 10; i++) begin
      push_wr(AW'(i), 7'(8'h61 + i));
      send(8'(8'h61 + i));
    end
    check_cursor("wrap", 2'd1, 4'd0);
    push_wr(5'd10, 7'h5A);
    send(8'h5A);
    check_cursor("z", 2'd1, 4'd1);
    push_wr(5'd10, 7'h20);
    send(CH_BS);
    check("bs_waddr", 32'(mem_waddr), 32'd10);
    check("bs_wdata", 32'(mem_wdata), 32'h20);
    check_cursor("bs", 2'd1, 4'd0);
    send(CH_BS);
    check("bs0_we", 32'(mem_we), 32'd0);
    check_cursor("bs0", 2'd1, 4'd0);
    send(8'h85);
    send(8'h01);
    check("ign_we", 32'(mem_we), 32'd0);
    check_cursor("ign", 2'd1, 4'd0);

    // LF to last row, preload, LF-triggered scroll
    send(CH_LF);
    check_cursor("lf", 2'd2, 4'd0);
    for (int i = 0; i < CELLS; i++) begin
      pre_en   = 1'b1;
      pre_addr = AW'(i);
      pre_data = 7'(8'h30 + i);
      shadow[i] = 7'(8'h30 + i);
      @(posedge clk); #1;
    end
    pre_en = 1'b0;
    for (int i = 0; i < CELLS; i++) push_wr(AW'(i), (i < 20) ? shadow[i + 10] : 7'h20);
    send(CH_LF);
    check("scr_ready", 32'(in_if.in_ready), 32'd0);
    check("scr_state", 32'(state_dbg), 32'(SCROLL));
    check_cursor("scr", 2'd2, 4'd0);
    wait_ready(cyc);
    check("scroll_cycles", 32'(cyc), 32'd30);
    @(negedge clk); #1;
    check("scroll_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

    // scroll stalled by vblank at idx 7
    for (int i = 0; i < CELLS; i++) push_wr(AW'(i), (i < 20) ? shadow[i + 10] : 7'h20);
    send(CH_LF);
    repeat (7) begin @(posedge clk); #1; end
    check("stall_pre_waddr", 32'(mem_waddr), 32'd6);
    vblank = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("stall_we", 32'(mem_we), 32'd0);
      check("stall_waddr", 32'(mem_waddr), 32'd6);
    end
    check("stall_rdaddr", 32'(mem_rd_addr), 32'd17);
    check("stall_state", 32'(state_dbg), 32'(SCROLL));
    vblank = 1'b1;
    @(posedge clk); #1;
    check("resume_we", 32'(mem_we), 32'd1);
    check("resume_waddr", 32'(mem_waddr), 32'd7);
    wait_ready(cyc);
    @(negedge clk); #1;
    check("stall_drained", 32'(exp_q.size()), 32'd0);
    check_cursor("stall", 2'd2, 4'd0);
    @(posedge clk); #1;

    // FF clear interrupted by reset at idx 12
    for (int i = 0; i < 12; i++) push_wr(AW'(i), 7'h20);
    send(CH_FF);
    check("ff_state", 32'(state_dbg), 32'(CLEAR));
    check_cursor("ff", 2'd0, 4'd0);
    repeat (12) begin @(posedge clk); #1; end
    check("ff_waddr", 32'(mem_waddr), 32'd11);
    @(negedge clk); #1;
    reset          = 1'b1;
    in_if.in_valid = 1'b1;
    in_if.in_data  = 8'h43;
    #1;
    check("midrst_we", 32'(mem_we), 32'd0);
    check("midrst_waddr", 32'(mem_waddr), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'(CLEAR));
    check("midrst_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < CELLS; i++) push_wr(AW'(i), 7'h20);
    push_wr(5'd0, 7'h43);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc = 0;
    while (!in_if.in_ready && cyc < 200) begin
      check("held_col", 32'(cursor_col), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    check("reclear_cycles", 32'(cyc), 32'd30);
    @(posedge clk); #1;
    in_if.in_valid = 1'b0;
    check("held_we", 32'(mem_we), 32'd1);
    check("held_waddr", 32'(mem_waddr), 32'd0);
    check_cursor("held", 2'd0, 4'd1);
    repeat (3) begin @(posedge clk); #1; end
    check_cursor("held_once", 2'd0, 4'd1);
    @(negedge clk); #1;
    check("final_drained", 32'(exp_q.size()), 32'd0);

    // report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
